sdram_test_engine: RTL and testbench
====================================

# sdram_test_engine

Parametrised SDRAM traffic generator and checker, successor to the fixed single-pattern async SDRAM tester. Fills a programmable address window through a valid/ready request port using one of four data patterns, reads the window back with several reads in flight, and checks every word. It reports sticky error, first-failure capture, error count and pass count. Sits between board-level control/LEDs and the SDRAM controller's user port in the same clock domain.

## Interface
- ADDR_W, 24, word address width
- DATA_W, 16, data width (≥ 8)
- MAX_OUTSTANDING, 4, read requests in flight (1..15)
- LFSR_SEED, 'h1, nonzero seed for the LFSR pattern
- clk  in  1  system clock
- reset_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle pulse; ignored while busy_o=1
- stop_i  in  1  clears loop latch; current pass completes
- mode_i  in  2  pattern: 0 index, 1 ~index, 2 LFSR, 3 walking one; sampled at start
- loop_i  in  1  repeat passes until stop_i; sampled at start
- base_i  in  ADDR_W  first word address; sampled at start
- count_i  in  ADDR_W  words per pass; sampled at start
- req_valid_o  out  1  request valid
- req_ready_i  in  1  controller accepts request
- req_we_o  out  1  1 = write, 0 = read
- req_addr_o  out  ADDR_W  word address
- req_wdata_o  out  DATA_W  write data
- rvalid_i  in  1  read data valid, in request order
- rdata_i  in  DATA_W  read data
- busy_o  out  1  test running
- done_o  out  1  one-cycle pulse at end of test
- error_o  out  1  sticky mismatch flag
- err_addr_o  out  ADDR_W  address of first mismatch
- err_exp_o / err_got_o  out  DATA_W  expected/received data of first mismatch
- err_cnt_o  out  16  mismatch count, saturating at 16'hFFFF
- pass_cnt_o  out  16  completed passes, wrapping

## Operation
- States: IDLE → WRITE → READ → DRAIN → (WRITE if loop latch set, else DONE) → IDLE. DONE lasts one cycle and asserts done_o.
- start_i in IDLE latches mode, loop, base and count. It clears error_o, err_*, err_cnt_o and pass_cnt_o, and restarts the issue pattern generator.
- count=0: IDLE → DONE directly, with no requests and no error.
- Word i (0..count-1) maps to address base+i, mod 2^ADDR_W (wraps).
- Patterns: index = i truncated or zero-extended to DATA_W; ~index; LFSR = maximal-length Galois LFSR over DATA_W bits, advanced once per word and restarted from LFSR_SEED at the start of each write phase and each read phase; walking one = 1 << (i mod DATA_W).
- WRITE: req_valid_o=1, req_we_o=1. The word index advances on each req_valid_o & req_ready_i handshake. After the last write handshake, the next state is READ.
- READ: issues reads for i=0..count-1. req_valid_o=1 only while outstanding < MAX_OUTSTANDING, where outstanding is the pre-update value. The outstanding counter increments on a read handshake and decrements on rvalid_i. Both in the same cycle leaves it unchanged. After the last read handshake, the next state is DRAIN.
- DRAIN: waits for outstanding=0. At that point pass_cnt_o increments and the loop latch selects the next state.
- Check: a separate check generator produces the expected word for each rvalid_i. On mismatch, err_cnt_o increments. On the first mismatch, error_o sets and err_addr_o/err_exp_o/err_got_o are captured.
- rvalid_i with outstanding=0 is ignored: no check, no counter change.
- Once valid, req_valid_o and the request fields hold stable until the handshake.

## Timing
- Reset: all outputs 0. State is IDLE, counters 0, generators at LFSR_SEED.
- Cycle n: start_i. Cycle n+1: busy_o=1, req_valid_o=1 with word 0.
- One handshake per cycle at most; back-to-back handshakes sustain 1 word/cycle.
- Error outputs update on the edge after the mismatching rvalid_i.
- done_o pulses in the cycle after DRAIN sees outstanding=0. busy_o drops in the same cycle.
- reset_n_i low mid-test aborts immediately; no further requests are issued.

## Structure
- Package sdram_test_pkg: mode_t enum, state_t enum, and an lfsr_next(DATA_W) function with the tap table for 8/16/32.
- Sub-module sdram_test_pattern: ports clk, reset_n_i, restart_i, advance_i, mode_i; output data_o. It holds the index counter and LFSR. It is instantiated twice, once as the issue generator and once as the check generator.

## Test plan
- Model: zero-wait memory, read latency 3. base=0x100, count=8, mode 0 → writes 0..7, error_o=0, done_o once, pass_cnt_o=1.
- Model: req_ready_i random at 50%, MAX_OUTSTANDING=4. mode 2, count=64 → error_o=0, outstanding never exceeds 4.
- Model flips bit 3 on read of address 0x105, mode 0, base 0x100 → error_o=1, err_addr_o=0x105, err_exp_o=0x0005, err_got_o=0x000D, err_cnt_o=1.
- base=0xFFFFFE, count=4 → addresses FFFFFE, FFFFFF, 000000, 000001. count=0 → done_o in 2 cycles, no requests.
- loop_i=1, mode 3, count=20, stop_i during pass 3 → pass_cnt_o=3, done_o once, walking one wraps at i=16.
- reset_n_i low during READ with 3 outstanding; stray rvalid_i after release → all outputs 0, no check performed.

Source files
------------

// File: rtl/sdram_test_pkg.sv
// Shared types and the LFSR step function for the SDRAM test engine.
// The LFSR is a right-shifting Galois form; the tap mask selects a maximal-length polynomial.
package sdram_test_pkg;

  typedef enum logic [1:0] {
    MODE_INDEX = 2'd0,
    MODE_INV   = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_WALK  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Widths outside the table fall back to x^w + 1, which is not maximal length.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] taps;
    case (width)
      8:       taps = 32'h0000_00B8;
      16:      taps = 32'h0000_B400;
      32:      taps = 32'h8020_0003;
      default: taps = (32'h1 << (width - 1)) | 32'h1;
    endcase
    return taps;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur, input int unsigned width);
    logic [31:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ lfsr_taps(width);
    return nxt;
  endfunction

endpackage

// File: rtl/sdram_test_pattern.sv
// Data pattern generator: word index, inverted index, Galois LFSR and walking one.
// restart_i rewinds to word 0; advance_i steps to the next word.
module sdram_test_pattern
  import sdram_test_pkg::*;
#(
  parameter int              DATA_W    = 16,
  parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              restart_i,
  input  logic              advance_i,
  input  mode_t             mode_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] idx_q;
  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] walk_q;

  // All three generators step together so switching modes never needs a resync.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idx_q  <= '0;
      lfsr_q <= LFSR_SEED;
      walk_q <= DATA_W'(1);
    end else if (restart_i) begin
      idx_q  <= '0;
      lfsr_q <= LFSR_SEED;
      walk_q <= DATA_W'(1);
    end else if (advance_i) begin
      idx_q  <= idx_q + DATA_W'(1);
      lfsr_q <= DATA_W'(lfsr_next(32'(lfsr_q), DATA_W));
      walk_q <= {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
    end
  end

  always_comb begin
    data_o = idx_q;
    case (mode_i)
      MODE_INDEX: data_o = idx_q;
      MODE_INV:   data_o = ~idx_q;
      MODE_LFSR:  data_o = lfsr_q;
      MODE_WALK:  data_o = walk_q;
      default:    data_o = idx_q;
    endcase
  end

endmodule

// File: rtl/sdram_test_engine.sv
// SDRAM traffic generator/checker: writes a pattern over an address window, reads it
// back with several reads in flight, and records the first and total mismatches.
module sdram_test_engine
  import sdram_test_pkg::*;
#(
  parameter int                ADDR_W          = 24,
  parameter int                DATA_W          = 16,
  parameter int                MAX_OUTSTANDING = 4,
  parameter logic [DATA_W-1:0] LFSR_SEED       = 'h1
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [1:0]        mode_i,
  input  logic              loop_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] count_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              rvalid_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [DATA_W-1:0] err_exp_o,
  output logic [DATA_W-1:0] err_got_o,
  output logic [15:0]       err_cnt_o,
  output logic [15:0]       pass_cnt_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic              loop_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] issue_idx_q;
  logic [ADDR_W-1:0] chk_idx_q;
  logic [OUT_W-1:0]  out_q;
  logic              error_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [DATA_W-1:0] err_exp_q;
  logic [DATA_W-1:0] err_got_q;
  logic [15:0]       err_cnt_q;
  logic [15:0]       pass_cnt_q;

  logic              start_ok;
  logic              req_valid;
  logic              hs;
  logic              last_issue;
  logic              wr_last;
  logic              rd_hs;
  logic              rd_accept;
  logic              drain_done;
  logic              mismatch;
  logic [DATA_W-1:0] issue_data;
  logic [DATA_W-1:0] chk_data;

  assign start_ok   = (state_q == ST_IDLE) && start_i;
  assign req_valid  = (state_q == ST_WRITE) ||
                      ((state_q == ST_READ) && (out_q < OUT_W'(MAX_OUTSTANDING)));
  assign hs         = req_valid && req_ready_i;
  assign last_issue = (issue_idx_q == ADDR_W'(count_q - ADDR_W'(1)));
  assign wr_last    = (state_q == ST_WRITE) && hs && last_issue;
  assign rd_hs      = (state_q == ST_READ) && hs;
  // Read data with nothing outstanding is stray and must not touch any state.
  assign rd_accept  = rvalid_i && (out_q != '0);
  assign drain_done = (state_q == ST_DRAIN) && (out_q == '0);
  assign mismatch   = rd_accept && (rdata_i != chk_data);

  sdram_test_pattern #(
    .DATA_W    (DATA_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_issue_gen (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .restart_i (start_ok || drain_done),
    .advance_i ((state_q == ST_WRITE) && hs),
    .mode_i    (mode_q),
    .data_o    (issue_data)
  );

  // The check generator rewinds as the read phase begins so it tracks read order.
  sdram_test_pattern #(
    .DATA_W    (DATA_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_check_gen (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .restart_i (start_ok || wr_last),
    .advance_i (rd_accept),
    .mode_i    (mode_q),
    .data_o    (chk_data)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = (count_i == '0) ? ST_DONE : ST_WRITE;
      ST_WRITE: if (hs && last_issue) state_d = ST_READ;
      ST_READ:  if (hs && last_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (out_q == '0) state_d = (loop_q && !stop_i) ? ST_WRITE : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mode_q  <= MODE_INDEX;
      loop_q  <= 1'b0;
      base_q  <= '0;
      count_q <= '0;
    end else if (start_ok) begin
      mode_q  <= mode_t'(mode_i);
      loop_q  <= loop_i;
      base_q  <= base_i;
      count_q <= count_i;
    end else if (stop_i) begin
      loop_q  <= 1'b0;
    end
  end

  // The issue index serves both phases, so it rewinds at every phase boundary.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      issue_idx_q <= '0;
      chk_idx_q   <= '0;
      out_q       <= '0;
    end else begin
      if (start_ok || wr_last || drain_done) issue_idx_q <= '0;
      else if (hs)                           issue_idx_q <= issue_idx_q + ADDR_W'(1);

      if (start_ok || wr_last) chk_idx_q <= '0;
      else if (rd_accept)      chk_idx_q <= chk_idx_q + ADDR_W'(1);

      if (rd_hs && !rd_accept)      out_q <= out_q + OUT_W'(1);
      else if (!rd_hs && rd_accept) out_q <= out_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
      err_cnt_q  <= '0;
      pass_cnt_q <= '0;
    end else if (start_ok) begin
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
      err_cnt_q  <= '0;
      pass_cnt_q <= '0;
    end else begin
      if (mismatch) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        if (!error_q) begin
          error_q    <= 1'b1;
          err_addr_q <= base_q + chk_idx_q;
          err_exp_q  <= chk_data;
          err_got_q  <= rdata_i;
        end
      end
      if (drain_done) pass_cnt_q <= pass_cnt_q + 16'd1;
    end
  end

  // Request fields are forced to zero when idle so the port is quiet outside a test.
  assign req_valid_o = req_valid;
  assign req_we_o    = (state_q == ST_WRITE);
  assign req_addr_o  = req_valid ? (base_q + issue_idx_q) : '0;
  assign req_wdata_o = (state_q == ST_WRITE) ? issue_data : '0;
  assign busy_o      = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done_o      = (state_q == ST_DONE);
  assign error_o     = error_q;
  assign err_addr_o  = err_addr_q;
  assign err_exp_o   = err_exp_q;
  assign err_got_o   = err_got_q;
  assign err_cnt_o   = err_cnt_q;
  assign pass_cnt_o  = pass_cnt_q;

endmodule

// File: tb/tb_sdram_test_engine.sv
// Self-checking bench for sdram_test_engine: a behavioural SDRAM model with fixed read
// latency plus a request scoreboard computed from the pattern definitions.
module tb_sdram_test_engine;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              reset_n_i, start_i, stop_i, loop_i;
  logic [1:0]        mode_i;
  logic [ADDR_W-1:0] base_i, count_i;
  logic              req_valid_o, req_ready_i, req_we_o;
  logic [ADDR_W-1:0] req_addr_o;
  logic [DATA_W-1:0] req_wdata_o;
  logic              rvalid_i;
  logic [DATA_W-1:0] rdata_i;
  logic              busy_o, done_o, error_o;
  logic [ADDR_W-1:0] err_addr_o;
  logic [DATA_W-1:0] err_exp_o, err_got_o;
  logic [15:0]       err_cnt_o, pass_cnt_o;

  int n_cmp;
  int n_fail;

  int                ready_pct;
  int                read_lat;
  bit                corrupt_en;
  logic [ADDR_W-1:0] corrupt_addr;
  bit                stray_req;
  logic [DATA_W-1:0] lfsr_tab [256];

  typedef struct {
    longint            due;
    logic [ADDR_W-1:0] addr;
  } rd_t;

  logic [DATA_W-1:0] mem [int];
  rd_t               pend [$];
  logic [ADDR_W-1:0] wr_addrs [$];
  logic [DATA_W-1:0] wr_data [$];
  longint            cyc = 0;
  int                mon_out = 0;
  int                max_out = 0;
  int                bad_req = 0;
  int                n_wr = 0;
  int                n_rd = 0;
  int                done_cnt = 0;
  int                tot_req = 0;
  bit                stray_done = 1'b0;
  logic [ADDR_W-1:0] exp_base = '0;
  int                exp_count = 0;
  logic [1:0]        exp_mode = '0;
  int                wi = 0;
  int                ri = 0;
  bit                prev_wait = 1'b0;
  logic              prev_we = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_wdata = '0;

  sdram_test_engine #(
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .MAX_OUTSTANDING (MAX_OUT),
    .LFSR_SEED       (16'h0001)
  ) dut (
    .clk         (clk),
    .reset_n_i   (reset_n_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .mode_i      (mode_i),
    .loop_i      (loop_i),
    .base_i      (base_i),
    .count_i     (count_i),
    .req_valid_o (req_valid_o),
    .req_ready_i (req_ready_i),
    .req_we_o    (req_we_o),
    .req_addr_o  (req_addr_o),
    .req_wdata_o (req_wdata_o),
    .rvalid_i    (rvalid_i),
    .rdata_i     (rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .err_addr_o  (err_addr_o),
    .err_exp_o   (err_exp_o),
    .err_got_o   (err_got_o),
    .err_cnt_o   (err_cnt_o),
    .pass_cnt_o  (pass_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] exp_pat(input logic [1:0] mode, input int i);
    case (mode)
      2'd0:    return DATA_W'(i);
      2'd1:    return ~DATA_W'(i);
      2'd2:    return lfsr_tab[i % 256];
      default: return DATA_W'(1) << (i % DATA_W);
    endcase
  endfunction

  // Memory model and request scoreboard; runs on the falling edge so every input it
  // drives is consumed by the following rising edge.
  always @(negedge clk) begin
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    int                out_before;
    if (!reset_n_i) begin
      pend.delete();
      mon_out     = 0;
      req_ready_i = 1'b0;
      rvalid_i    = 1'b0;
      rdata_i     = '0;
      prev_wait   = 1'b0;
    end else begin
      if (start_i && !busy_o) begin
        exp_base  = base_i;
        exp_count = int'(count_i);
        exp_mode  = mode_i;
        wi = 0; ri = 0; n_wr = 0; n_rd = 0; done_cnt = 0; max_out = 0; bad_req = 0;
        wr_addrs.delete();
        wr_data.delete();
      end
      if (prev_wait && (!req_valid_o || req_we_o != prev_we ||
                        req_addr_o != prev_addr || req_wdata_o != prev_wdata))
        bad_req++;
      req_ready_i = ($urandom_range(99, 0) < ready_pct);
      out_before  = mon_out;
      if (req_valid_o && req_ready_i) begin
        tot_req++;
        if (req_we_o) begin
          a = exp_base + ADDR_W'(wi);
          if (req_addr_o != a || req_wdata_o != exp_pat(exp_mode, wi)) bad_req++;
          mem[int'(req_addr_o)] = req_wdata_o;
          wr_addrs.push_back(req_addr_o);
          wr_data.push_back(req_wdata_o);
          n_wr++;
          wi = (wi + 1 == exp_count) ? 0 : wi + 1;
        end else begin
          a = exp_base + ADDR_W'(ri);
          if (req_addr_o != a || out_before >= MAX_OUT) bad_req++;
          pend.push_back('{cyc + longint'(read_lat), req_addr_o});
          mon_out++;
          n_rd++;
          ri = (ri + 1 == exp_count) ? 0 : ri + 1;
        end
      end
      prev_wait  = req_valid_o && !req_ready_i;
      prev_we    = req_we_o;
      prev_addr  = req_addr_o;
      prev_wdata = req_wdata_o;
      if (stray_req && !stray_done) begin
        rvalid_i   = 1'b1;
        rdata_i    = DATA_W'($urandom);
        stray_done = 1'b1;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        a = pend[0].addr;
        void'(pend.pop_front());
        d = mem.exists(int'(a)) ? mem[int'(a)] : '0;
        if (corrupt_en && a == corrupt_addr) d[3] = ~d[3];
        rdata_i  = d;
        rvalid_i = 1'b1;
        mon_out--;
      end else begin
        rvalid_i = 1'b0;
      end
      if (mon_out > max_out) max_out = mon_out;
      if (done_o) begin
        done_cnt++;
        if (busy_o) bad_req++;
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic loop,
                               input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count);
    @(posedge clk);
    #1;
    mode_i  = mode;
    loop_i  = loop;
    base_i  = base;
    count_i = count;
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (done_o) seen = 1'b1;
      else tick(1);
    end
    checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) checkOutput({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ctl"}, 64'({req_valid_o, req_we_o, busy_o, done_o, error_o}), 64'd0);
    checkOutput({tag, "_addr"}, 64'(req_addr_o), 64'd0);
    checkOutput({tag, "_wdata"}, 64'(req_wdata_o), 64'd0);
    checkOutput({tag, "_err_addr"}, 64'(err_addr_o), 64'd0);
    checkOutput({tag, "_err_data"}, 64'({err_exp_o, err_got_o}), 64'd0);
    checkOutput({tag, "_err_cnt"}, 64'(err_cnt_o), 64'd0);
    checkOutput({tag, "_pass_cnt"}, 64'(pass_cnt_o), 64'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] c;
    int                snap;
    bit                hit;

    n_cmp = 0; n_fail = 0;
    ready_pct = 100; read_lat = 3; corrupt_en = 1'b0; corrupt_addr = '0; stray_req = 1'b0;
    lfsr_tab[0] = 16'h0001;
    for (int k = 1; k < 256; k++)
      lfsr_tab[k] = (lfsr_tab[k-1] >> 1) ^ (lfsr_tab[k-1][0] ? 16'hB400 : 16'h0000);

    reset_n_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0;
    mode_i = '0; base_i = '0; count_i = '0;
    tick(3);
    check_all_zero("reset");
    reset_n_i = 1'b1;
    tick(2);

    $display("[TB] basic index fill, base 0x100 count 8");
    applyStimulus(2'd0, 1'b0, 24'h000100, 24'd8);
    checkOutput("t1_busy_n1", 64'(busy_o), 64'd1);
    checkOutput("t1_valid_n1", 64'({req_valid_o, req_we_o}), 64'b11);
    checkOutput("t1_addr_n1", 64'(req_addr_o), 64'h100);
    checkOutput("t1_wdata_n1", 64'(req_wdata_o), 64'h0);
    wait_done("t1", 200);
    tick(3);
    checkOutput("t1_error", 64'(error_o), 64'd0);
    checkOutput("t1_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("t1_pass_cnt", 64'(pass_cnt_o), 64'd1);
    checkOutput("t1_wr_rd", 64'({n_wr[15:0], n_rd[15:0]}), {32'd0, 16'd8, 16'd8});
    checkOutput("t1_last_wdata", 64'(wr_data[7]), 64'h7);
    checkOutput("t1_scoreboard", 64'(bad_req), 64'd0);

    $display("[TB] LFSR fill with random ready");
    ready_pct = 50;
    b = ADDR_W'($urandom);
    applyStimulus(2'd2, 1'b0, b, 24'd64);
    wait_done("t2", 3000);
    tick(2);
    checkOutput("t2_error", 64'(error_o), 64'd0);
    checkOutput("t2_max_out_le4", 64'(max_out <= MAX_OUT), 64'd1);
    checkOutput("t2_wr_rd", 64'({n_wr[15:0], n_rd[15:0]}), {32'd0, 16'd64, 16'd64});
    checkOutput("t2_scoreboard", 64'(bad_req), 64'd0);

    $display("[TB] inverted index with long read latency");
    ready_pct = 100; read_lat = 8;
    b = ADDR_W'($urandom);
    c = ADDR_W'($urandom_range(40, 10));
    applyStimulus(2'd1, 1'b0, b, c);
    wait_done("t2b", 2000);
    tick(2);
    checkOutput("t2b_max_out_eq4", 64'(max_out), 64'd4);
    checkOutput("t2b_error", 64'(error_o), 64'd0);
    checkOutput("t2b_scoreboard", 64'(bad_req), 64'd0);
    read_lat = 3;

    $display("[TB] injected bit flip at 0x105");
    corrupt_en = 1'b1; corrupt_addr = 24'h000105;
    applyStimulus(2'd0, 1'b0, 24'h000100, 24'd8);
    wait_done("t3", 200);
    tick(2);
    corrupt_en = 1'b0;
    checkOutput("t3_error", 64'(error_o), 64'd1);
    checkOutput("t3_err_addr", 64'(err_addr_o), 64'h105);
    checkOutput("t3_err_exp", 64'(err_exp_o), 64'h0005);
    checkOutput("t3_err_got", 64'(err_got_o), 64'h000D);
    checkOutput("t3_err_cnt", 64'(err_cnt_o), 64'd1);

    $display("[TB] address wrap at top of space");
    applyStimulus(2'($urandom_range(3, 0)), 1'b0, 24'hFFFFFE, 24'd4);
    wait_done("t4", 200);
    tick(2);
    checkOutput("t4_n_wr", 64'(wr_addrs.size()), 64'd4);
    if (wr_addrs.size() == 4)
      checkOutput("t4_addrs", {16'd0, wr_addrs[0][15:0], wr_addrs[1][15:0], wr_addrs[2][15:0]},
                  {16'd0, 16'hFFFE, 16'hFFFF, 16'h0000});
    checkOutput("t4_addr3", 64'(wr_addrs.size() == 4 ? wr_addrs[3] : 24'hDEAD), 64'h000001);
    checkOutput("t4_error", 64'(error_o), 64'd0);
    checkOutput("t4_scoreboard", 64'(bad_req), 64'd0);

    $display("[TB] zero-length test");
    snap = tot_req;
    applyStimulus(2'd0, 1'b0, 24'h000200, 24'd0);
    wait_done("t5", 2);
    tick(3);
    checkOutput("t5_no_requests", 64'(tot_req - snap), 64'd0);
    checkOutput("t5_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("t5_error", 64'(error_o), 64'd0);

    $display("[TB] looping walking one, stop during pass 3");
    applyStimulus(2'd3, 1'b1, ADDR_W'($urandom), 24'd20);
    hit = 1'b0;
    for (int k = 0; k < 500 && !hit; k++) begin
      if (pass_cnt_o == 16'd2) hit = 1'b1;
      else tick(1);
    end
    checkOutput("t6_reached_pass2", 64'(hit), 64'd1);
    tick(5);
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    wait_done("t6", 500);
    tick(3);
    checkOutput("t6_pass_cnt", 64'(pass_cnt_o), 64'd3);
    checkOutput("t6_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("t6_n_wr", 64'(n_wr), 64'd60);
    if (wr_data.size() == 60)
      checkOutput("t6_walk_wrap", {16'd0, wr_data[15], wr_data[16], wr_data[36]},
                  {16'd0, 16'h8000, 16'h0001, 16'h0001});
    checkOutput("t6_error", 64'(error_o), 64'd0);
    checkOutput("t6_scoreboard", 64'(bad_req), 64'd0);

    $display("[TB] reset during read phase, then stray read data");
    applyStimulus(2'd0, 1'b0, ADDR_W'($urandom), 24'd64);
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      if (mon_out == 3 && req_valid_o && !req_we_o) hit = 1'b1;
      else tick(1);
    end
    checkOutput("t7_reached_3_outstanding", 64'(hit), 64'd1);
    reset_n_i = 1'b0;
    #1;
    check_all_zero("t7_abort");
    snap = tot_req;
    tick(2);
    reset_n_i = 1'b1;
    stray_req = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      if (stray_done) hit = 1'b1;
      else tick(1);
    end
    checkOutput("t7_stray_sent", 64'(hit), 64'd1);
    tick(4);
    check_all_zero("t7_after_stray");
    checkOutput("t7_no_requests", 64'(tot_req - snap), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
